// File: rtl/mem_arb_pkg.sv
// Shared widths and enums for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int SEG_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_F,
    PORT_D
  } port_sel_t;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch port, data port and memory pins of the arbiter, bundled as one interface.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic              f_req;
  logic [SEG_W-1:0]  f_seg;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ready;
  logic              f_valid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [SEG_W-1:0]  d_seg;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_r_wb;
  logic [SEG_W-1:0]  mem_plus;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;

  modport slave (
    input  f_req, f_seg, f_addr,
    output f_ready, f_valid, f_rdata,
    input  d_req, d_we, d_seg, d_addr, d_wdata,
    output d_ready, d_valid, d_rdata,
    output mem_en, mem_r_wb, mem_plus, mem_addr, mem_din,
    input  mem_dout,
    output busy
  );

  modport master (
    output f_req, f_seg, f_addr,
    input  f_ready, f_valid, f_rdata,
    output d_req, d_we, d_seg, d_addr, d_wdata,
    input  d_ready, d_valid, d_rdata,
    input  mem_en, mem_r_wb, mem_plus, mem_addr, mem_din,
    output mem_dout,
    input  busy
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant selection (data priority with a starvation escape) and
// the next value of the starvation counter.
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             idle,
  input  logic             f_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_f,
  output logic             grant_d,
  output logic [CNT_W-1:0] starve_nxt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic at_limit;
  assign at_limit = (starve_cnt == LIMIT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    starve_nxt = starve_cnt;

    if (idle) begin
      if (d_req && !(f_req && at_limit)) grant_d = 1'b1;
      else if (f_req)                    grant_f = 1'b1;
    end

    // A data grant only counts against the fetch port while fetch is waiting.
    if (grant_d && f_req)       starve_nxt = at_limit ? LIMIT : starve_cnt + 1'b1;
    else if (grant_d || grant_f) starve_nxt = '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported word memory between the fetch and load/store ports:
// grants, drives registered memory pins, captures read data, pulses valid.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_q, state_d;
  port_sel_t         owner_q;
  logic              wr_q;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              grant_f, grant_d;

  logic              mem_en_q, mem_r_wb_q;
  logic [SEG_W-1:0]  mem_plus_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_grant (
    .idle      (state_q == IDLE),
    .f_req     (bus.f_req),
    .d_req     (bus.d_req),
    .starve_cnt(starve_cnt),
    .grant_f   (grant_f),
    .grant_d   (grant_d),
    .starve_nxt(starve_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_f || grant_d) state_d = ISSUE;
      ISSUE:   state_d = wr_q ? RESP : CAPT;
      CAPT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= PORT_F;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
      mem_en_q   <= 1'b0;
      mem_r_wb_q <= 1'b1;
      mem_plus_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_nxt;
      unique case (state_q)
        IDLE: begin
          if (grant_f || grant_d) begin
            mem_en_q   <= 1'b1;
            owner_q    <= grant_d ? PORT_D : PORT_F;
            wr_q       <= grant_d && bus.d_we;
            mem_r_wb_q <= !(grant_d && bus.d_we);
            mem_plus_q <= grant_d ? bus.d_seg  : bus.f_seg;
            mem_addr_q <= grant_d ? bus.d_addr : bus.f_addr;
            if (grant_d && bus.d_we) mem_din_q <= bus.d_wdata;
          end
        end
        ISSUE: begin
          // Reads keep the pins asserted one more cycle so mem_dout stays defined at capture.
          if (wr_q) begin
            mem_en_q   <= 1'b0;
            mem_r_wb_q <= 1'b1;
          end
        end
        CAPT: begin
          mem_en_q   <= 1'b0;
          mem_r_wb_q <= 1'b1;
          if (owner_q == PORT_D) d_rdata_q <= bus.mem_dout;
          else                   f_rdata_q <= bus.mem_dout;
        end
        default: ;
      endcase
    end
  end

  assign bus.f_ready  = grant_f;
  assign bus.d_ready  = grant_d;
  assign bus.f_valid  = (state_q == RESP) && (owner_q == PORT_F);
  assign bus.d_valid  = (state_q == RESP) && (owner_q == PORT_D);
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_r_wb = mem_r_wb_q;
  assign bus.mem_plus = mem_plus_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of grant order, latency and memory contents.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Power-up contents of the memory, with the seed word used by the fetch scenario.
  function automatic logic [15:0] init_word(input int a);
    if (a == 32'h305A) return 16'h1234;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Memory stub: synchronous single port, data_out undefined unless reading.
  logic [15:0] mem_store [0:65535];
  bit          written   [0:65535];

  function automatic logic [15:0] stub_read(input int a);
    return written[a] ? mem_store[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_r_wb) begin
      mem_store[{bus.mem_plus, bus.mem_addr}] <= bus.mem_din;
      written[{bus.mem_plus, bus.mem_addr}]   <= 1'b1;
    end
    bus.mem_dout <= (bus.mem_en && bus.mem_r_wb) ? stub_read(int'({bus.mem_plus, bus.mem_addr})) : 16'hxxxx;
  end

  // Reference memory contents as seen by the model.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int k = 0; k < 12 && who < 0; k++) begin
      @(negedge clk);
      if (bus.f_ready && bus.d_ready) who = 2;
      else if (bus.d_ready)           who = 1;
      else if (bus.f_ready)           who = 0;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // Model state for the randomized phase.
  int          free_at, resp_at, en_from, en_to, starve, who, a;
  bit          resp_d, resp_rd, fp, dp, idle, eg_f, eg_d, wr;
  logic [15:0] resp_data, exp_f_rdata, exp_d_rdata, exp_din;
  logic [3:0]  exp_seg;
  logic [11:0] exp_addr;
  bit          exp_rwb;

  initial begin
    bus.f_req = 0; bus.f_seg = '0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_seg = '0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_mem_en",   bus.mem_en,   0);
    chk("rst_mem_r_wb", bus.mem_r_wb, 1);
    chk("rst_mem_plus", bus.mem_plus, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din",  bus.mem_din,  0);
    chk("rst_f_rdata",  bus.f_rdata,  0);
    chk("rst_d_rdata",  bus.d_rdata,  0);
    chk("rst_readys",   {bus.f_ready, bus.d_ready}, 0);
    chk("rst_valids",   {bus.f_valid, bus.d_valid}, 0);
    chk("rst_busy",     bus.busy,     0);
    next_cycle();
    rst = 1'b0;

    // Fetch read of 0x3_05A
    bus.f_req = 1; bus.f_seg = 4'h3; bus.f_addr = 12'h05A;
    @(negedge clk);
    chk("fr_f_ready", bus.f_ready, 1);
    chk("fr_d_ready", bus.d_ready, 0);
    next_cycle();
    bus.f_req = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("fr_mem_en_t%0d", k),   bus.mem_en,   1);
      chk($sformatf("fr_mem_plus_t%0d", k), bus.mem_plus, 4'h3);
      chk($sformatf("fr_mem_addr_t%0d", k), bus.mem_addr, 12'h05A);
      chk($sformatf("fr_mem_r_wb_t%0d", k), bus.mem_r_wb, 1);
      chk($sformatf("fr_f_valid_t%0d", k),  bus.f_valid,  0);
      next_cycle();
    end
    @(negedge clk);
    chk("fr_f_valid_t3", bus.f_valid, 1);
    chk("fr_f_rdata_t3", bus.f_rdata, 16'h1234);
    chk("fr_mem_en_t3",  bus.mem_en,  0);
    next_cycle();
    @(negedge clk);
    chk("fr_f_valid_t4", bus.f_valid, 0);
    chk("fr_busy_t4",    bus.busy,    0);
    next_cycle();

    // Data write of 0xBEEF to 0x0_FFF, then read back
    bus.d_req = 1; bus.d_we = 1; bus.d_seg = 4'h0; bus.d_addr = 12'hFFF; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_d_ready", bus.d_ready, 1);
    next_cycle();
    bus.d_req = 0;
    @(negedge clk);
    chk("wr_mem_en_t1",   bus.mem_en,   1);
    chk("wr_mem_r_wb_t1", bus.mem_r_wb, 0);
    chk("wr_mem_din_t1",  bus.mem_din,  16'hBEEF);
    chk("wr_mem_addr_t1", bus.mem_addr, 12'hFFF);
    chk("wr_mem_plus_t1", bus.mem_plus, 4'h0);
    next_cycle();
    @(negedge clk);
    chk("wr_d_valid_t2",  bus.d_valid,  1);
    chk("wr_mem_en_t2",   bus.mem_en,   0);
    chk("wr_mem_r_wb_t2", bus.mem_r_wb, 1);
    chk("wr_d_rdata_t2",  bus.d_rdata,  0);
    next_cycle();
    bus.d_req = 1; bus.d_we = 0;
    @(negedge clk);
    chk("rb_d_ready", bus.d_ready, 1);
    next_cycle();
    bus.d_req = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rb_d_valid", bus.d_valid, 1);
    chk("rb_d_rdata", bus.d_rdata, 16'hBEEF);
    next_cycle();

    // Simultaneous requests: data wins, fetch follows once idle
    bus.f_req = 1; bus.f_seg = 4'h3; bus.f_addr = 12'h05A;
    bus.d_req = 1; bus.d_we = 0;
    @(negedge clk);
    chk("sim_d_ready", bus.d_ready, 1);
    chk("sim_f_ready", bus.f_ready, 0);
    next_cycle();
    bus.d_req = 0;
    @(negedge clk);
    chk("sim_f_ready_busy", bus.f_ready, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("sim_d_valid", bus.d_valid, 1);
    chk("sim_d_rdata", bus.d_rdata, 16'hBEEF);
    next_cycle();
    @(negedge clk);
    chk("sim_f_ready_late", bus.f_ready, 1);
    chk("sim_d_ready_late", bus.d_ready, 0);
    next_cycle();
    bus.f_req = 0;
    repeat (4) next_cycle();

    // Starvation: both held high; data writes four times, then one fetch
    bus.f_req = 1; bus.f_seg = 4'h3; bus.f_addr = 12'h05A;
    bus.d_req = 1; bus.d_we = 1; bus.d_seg = 4'h2; bus.d_addr = 12'h010; bus.d_wdata = 16'hCAFE;
    for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
      wait_grant(who);
      chk($sformatf("starve_grant%0d", g), who, (g % (LIMIT + 1) == LIMIT) ? 0 : 1);
    end
    bus.f_req = 0; bus.d_req = 0;
    repeat (5) next_cycle();

    // Reset during CAPT drops the fetch read
    @(negedge clk);
    chk("mr_pre_f_rdata", bus.f_rdata, 16'h1234);
    next_cycle();
    bus.f_req = 1; bus.f_seg = 4'h3; bus.f_addr = 12'h05A;
    @(negedge clk);
    chk("mr_f_ready", bus.f_ready, 1);
    next_cycle();
    bus.f_req = 0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy",    bus.busy,    0);
    chk("mr_mem_en",  bus.mem_en,  0);
    chk("mr_f_valid", bus.f_valid, 0);
    chk("mr_f_rdata", bus.f_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("mr_f_valid_after", bus.f_valid, 0);
    next_cycle();

    // No requests for ten cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle_mem_en%0d", k),   bus.mem_en,   0);
      chk($sformatf("idle_busy%0d", k),     bus.busy,     0);
      chk($sformatf("idle_mem_r_wb%0d", k), bus.mem_r_wb, 1);
      next_cycle();
    end

    // Randomized traffic against the transaction model
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    free_at = 0; resp_at = -1; en_from = 1; en_to = 0; starve = 0;
    exp_f_rdata = '0; exp_d_rdata = '0; fp = 0; dp = 0;
    resp_d = 0; resp_rd = 0; resp_data = '0; exp_din = '0;
    exp_seg = '0; exp_addr = '0; exp_rwb = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!fp && $urandom_range(0, 1) == 1) begin
        fp = 1;
        bus.f_seg  = 4'(8 + $urandom_range(0, 1));
        bus.f_addr = 12'($urandom_range(0, 7));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_seg   = 4'(8 + $urandom_range(0, 1));
        bus.d_addr  = 12'($urandom_range(0, 7));
        bus.d_wdata = 16'($urandom);
      end
      bus.f_req = fp;
      bus.d_req = dp;
      @(negedge clk);

      idle = (cyc >= free_at);
      eg_d = idle && dp && !(fp && starve == LIMIT);
      eg_f = idle && fp && !eg_d;
      chk("rnd_f_ready", bus.f_ready, eg_f);
      chk("rnd_d_ready", bus.d_ready, eg_d);
      chk("rnd_busy",    bus.busy,    !idle);
      chk("rnd_mem_en",  bus.mem_en,  (cyc >= en_from && cyc <= en_to));
      if (cyc >= en_from && cyc <= en_to) begin
        chk("rnd_mem_plus", bus.mem_plus, exp_seg);
        chk("rnd_mem_addr", bus.mem_addr, exp_addr);
        chk("rnd_mem_r_wb", bus.mem_r_wb, exp_rwb);
        if (!exp_rwb) chk("rnd_mem_din", bus.mem_din, exp_din);
      end else begin
        chk("rnd_mem_r_wb_idle", bus.mem_r_wb, 1);
      end
      if (cyc == resp_at && resp_rd) begin
        if (resp_d) exp_d_rdata = resp_data;
        else        exp_f_rdata = resp_data;
      end
      chk("rnd_f_valid", bus.f_valid, (cyc == resp_at) && !resp_d);
      chk("rnd_d_valid", bus.d_valid, (cyc == resp_at) && resp_d);
      chk("rnd_f_rdata", bus.f_rdata, exp_f_rdata);
      chk("rnd_d_rdata", bus.d_rdata, exp_d_rdata);

      if (eg_f || eg_d) begin
        wr       = eg_d && bus.d_we;
        exp_seg  = eg_d ? bus.d_seg  : bus.f_seg;
        exp_addr = eg_d ? bus.d_addr : bus.f_addr;
        exp_rwb  = !wr;
        a        = int'({exp_seg, exp_addr});
        resp_d   = eg_d;
        resp_rd  = !wr;
        resp_at  = cyc + (wr ? 2 : 3);
        free_at  = cyc + (wr ? 3 : 4);
        en_from  = cyc + 1;
        en_to    = cyc + (wr ? 1 : 2);
        if (wr) begin
          exp_din    = bus.d_wdata;
          ref_mem[a] = bus.d_wdata;
        end else begin
          resp_data = ref_read(a);
        end
        if (eg_d) starve = fp ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        else      starve = 0;
        if (eg_d) dp = 0;
        else      fp = 0;
      end
      next_cycle();
    end
    bus.f_req = 0; bus.d_req = 0;
    repeat (5) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port controller that shares the single-ported 16-bit word memory between the instruction-fetch unit (read-only) and the load/store data unit (read/write). It accepts requests on two port handshakes, sequences the memory's `enable`/`r_wb`/segment/address/data pins, captures read data, and returns a one-cycle response pulse. The data port has fixed priority, and a starvation counter forces a fetch grant after a bounded run of data grants. It sits between the CPU core's fetch/LSU stages and the memory module.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive data-port grants while `f_req` is pending; must be ≥1.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `f_req` in 1: fetch request; held with `f_seg`/`f_addr` stable until `f_ready`.
- `f_seg` in 4, `f_addr` in 12: fetch segment and word address; physical address is {seg, addr}.
- `f_ready` out 1: one-cycle accept pulse for the fetch request.
- `f_valid` out 1: one-cycle pulse; `f_rdata` is valid in that cycle.
- `f_rdata` out 16: fetch read data; holds its last value.
- `d_req` in 1, `d_we` in 1 (1 = write), `d_seg` in 4, `d_addr` in 12, `d_wdata` in 16: data-port request; all held stable until `d_ready`.
- `d_ready` out 1: one-cycle accept pulse for the data request.
- `d_valid` out 1: one-cycle pulse. It is the read-data strobe for a read and the completion acknowledge for a write.
- `d_rdata` out 16: data-port read data; holds its last value and is unchanged by writes.
- `mem_en`, `mem_r_wb` out 1: drive the memory `enable` and `r_wb` pins.
- `mem_plus` out 4, `mem_addr` out 12, `mem_din` out 16: drive the memory `plus`, `address` and `data_in` pins.
- `mem_dout` in 16: memory `data_out`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, CAPT, RESP. All memory-side outputs are registered.
- **Grant (IDLE only):** combinational `f_ready`/`d_ready`, at most one high per cycle.
  - If `d_req` and not (`f_req` and `starve_cnt == STARVE_LIMIT`): grant data.
  - Otherwise, if `f_req`: grant fetch.
- **Starvation counter (`starve_cnt`):**
  - Increments on a data grant while `f_req` is high.
  - Clears on a fetch grant, or on a data grant while `f_req` is low.
  - Saturates at STARVE_LIMIT.
- **On grant:** register the physical address and, for writes, `mem_din = d_wdata`.
  - Set `mem_en = 1`.
  - Set `mem_r_wb = 0` for a data write, 1 otherwise.
  - Record which port was granted and the access type. Next state is ISSUE.
- **ISSUE:** memory samples the pins at the closing edge.
  - Read: next state is CAPT with `mem_en` kept at 1 and all pins unchanged. This re-reads the same word so `mem_dout` never goes X while it is being captured.
  - Write: next state is RESP with `mem_en = 0`.
- **CAPT:** at the closing edge, latch `mem_dout` into the owner's rdata register, drop `mem_en`, and go to RESP.
- **RESP:** owner's `valid = 1` for exactly this cycle; next state is IDLE.
- **`mem_en = 0` defaults:** `mem_r_wb = 1`; `mem_plus`, `mem_addr` and `mem_din` hold their last values.
- **Requests outside IDLE** are not accepted; `f_ready` and `d_ready` are 0.
- **Reset values:** state IDLE; `mem_en` 0; `mem_r_wb` 1; `mem_plus`, `mem_addr`, `mem_din`, `f_rdata` and `d_rdata` all 0; every ready/valid 0; `busy` 0; `starve_cnt` 0.
- **Reset mid-operation:** the next state is IDLE and the in-flight transaction is dropped with no `valid` pulse. A write whose ISSUE edge coincides with `rst` still commits in memory; this is accepted behaviour.

## Timing
- Accept in cycle T (ready high).
  - Read: `mem_en` high in T+1 and T+2; `valid` in T+3 (3-cycle latency).
  - Write: `mem_en` high in T+1; `valid` in T+2.
- The next accept is possible at the earliest in T+4 for a read and T+3 for a write. Peak throughput is one read per 4 cycles.
- `req` is level, not edge. A requester that keeps `req` high after `ready` issues a new request.

## Structure
- Package `mem_arb_pkg` holds:
  - widths `DATA_W=16`, `ADDR_W=12`, `SEG_W=4`;
  - the state enum `arb_state_t` {IDLE, ISSUE, CAPT, RESP};
  - the port-select enum {PORT_F, PORT_D}.
- One sub-module, `mem_arb_grant`: purely combinational grant selection plus the next value of `starve_cnt`. The FSM and registers stay in `mem_arbiter`.

## Test plan
- **Fetch read:** memory word 0x1234 at 0x3_05A; `f_req`, seg=3, addr=0x05A → `f_ready` at T; `mem_en` high in T+1..T+2 with `mem_plus`=3, `mem_addr`=0x05A, `mem_r_wb`=1; `f_valid` with `f_rdata`=0x1234 at T+3.
- **Data write then read-back:** write 0xBEEF to 0x0_FFF → `mem_r_wb`=0 for one cycle and `d_valid` at T+2; the following read of 0x0_FFF returns `d_rdata`=0xBEEF.
- **Simultaneous requests:** `f_req` and `d_req` high in the same IDLE cycle → `d_ready` only; fetch is granted in the next IDLE cycle once `d_req` drops.
- **Starvation:** `d_req` held high continuously with `f_req` high, STARVE_LIMIT=4 → 4 data grants, then 1 fetch grant, then data grants resume; `starve_cnt` returns to 0 after the fetch grant.
- **Reset mid-read:** `rst` asserted during the CAPT cycle → next cycle IDLE, `mem_en`=0, no `f_valid`, `f_rdata` reads 0.
- **No-request idle:** both `req` low for 10 cycles → `mem_en`=0 and `busy`=0 throughout; `mem_r_wb`=1.
